block_serial_subtractor: RTL
============================

Name: block_serial_subtractor

Overview:
- Multi-cycle subtractor computing DIFF = A - B - BIN.
- Processes one BLOCK-bit slice per clock, LSB slice first; the borrow is held in a register between slices.
- Each slice uses a borrow-bypass path: when the A and B slices are equal, borrow-out equals borrow-in.
- Sits beside the combinational adder datapath in the ALU. It is the subtract-direction, area-reduced counterpart, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of BLOCK.
- BLOCK, 8, slice width processed per cycle.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  minuend, sampled on accept
- b  input  WIDTH  subtrahend, sampled on accept
- bin  input  1  borrow-in, sampled on accept
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  registered difference
- bout  output  1  final borrow-out; 1 iff unsigned a < b + bin
- zero  output  1  diff == 0
- neg  output  1  diff[WIDTH-1]
- ovf  output  1  signed overflow of a - b - bin

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (asynchronous, any state, including mid-CALC):
  - state = IDLE, slice index = 0, borrow register = 0.
  - diff = 0; bout, zero, neg, ovf = 0; out_valid = 0.
  - in_ready = 1 once reset is released.
  - No partial result survives reset.
- States:
  - IDLE -> CALC on accept (in_valid && in_ready). Latch a, b; borrow register = bin; index = 0.
  - CALC: each edge processes slice k = index:
    - d_k = a_k - b_k - borrow.
    - Slice borrow-out = borrow when a_k == b_k (bypass); otherwise the ripple borrow of the slice.
    - Write d_k into diff[k*BLOCK +: BLOCK]; update borrow; index + 1.
    - After slice WIDTH/BLOCK-1: go to DONE, load bout from the final borrow, compute flags.
  - DONE: out_valid = 1; diff and flags held stable. On out_valid && out_ready -> IDLE, out_valid drops next edge.
- Latency: accept at edge T; slices processed at edges T+1 .. T+4 (defaults); out_valid high from edge T+4. Minimum 4 cycles accept-to-result.
- Minimum issue interval: 6 cycles (accept, 4 CALC, DONE→IDLE), assuming out_ready held high.
- Handshake rules:
  - in_ready is a combinational decode of state == IDLE.
  - in_valid ignored outside IDLE.
  - out_ready ignored outside DONE.
  - in_valid in the same cycle DONE exits is not accepted; accept occurs in the following IDLE cycle.
  - in_valid in IDLE while the previous result was never consumed cannot occur (DONE blocks).
- Operand isolation: a/b/bin changes after accept have no effect; operands are registered.
- diff contents during CALC are undefined to consumers (out_valid = 0), but unwritten slices keep their prior values; no X.
- Flags, computed from the complete result on CALC -> DONE transition:
  - zero = (diff == 0).
  - neg = diff[WIDTH-1].
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
- Wrap-around: result is modulo 2^WIDTH; 0 - 1 gives all ones with bout = 1.
- bin = 1 with a == b: every slice bypasses; borrow propagates through all slices; diff = all ones, bout = 1.
- Back-pressure: out_ready low holds DONE indefinitely; outputs unchanged.

Test Plan:
- Reset mid-CALC: assert rst_n low at edge T+2 after an accept. Required: out_valid=0, in_ready=1, diff=0, flags=0 immediately. A new operation then completes normally.
- Basic: a=0x0000_0010, b=0x0000_0003, bin=0. Required: out_valid exactly 4 cycles after accept; diff=0x0000_000D, bout=0, zero=0, neg=0, ovf=0.
- Full bypass: a=0x1234_5678, b=0x1234_5678, bin=1. Required: diff=0xFFFF_FFFF, bout=1, neg=1, zero=0, ovf=0. Also a==b with bin=0 -> diff=0, zero=1, bout=0.
- Wrap/overflow:
  - a=0x0000_0000, b=0x0000_0001 -> diff=0xFFFF_FFFF, bout=1, ovf=0.
  - a=0x8000_0000, b=0x0000_0001 -> diff=0x7FFF_FFFF, bout=0, ovf=1.
- Back-pressure and handshake:
  - Hold out_ready=0 for 10 cycles. Required: diff and flags stable, in_ready=0; in_valid pulses during CALC/DONE are ignored.
  - Then raise out_ready together with in_valid. Required: new operands accepted only in the following IDLE cycle.
- Random regression: 10k random a/b/bin issued back-to-back. Required: diff, bout, zero, neg and ovf all match the reference model a-b-bin every transaction.

Source files
------------

// File: rtl/block_serial_subtractor.sv
// block_serial_subtractor
// Multi-cycle subtractor computing diff = a - b - bin one BLOCK-bit slice per
// clock, least significant slice first, with the inter-slice borrow held in a
// register. It is the area-reduced subtract-direction partner of the
// combinational adder in the ALU.
//
// Ports:
//    clk        rising-edge clock
//    rst_n      asynchronous active-low reset
//    in_valid   operand request valid
//    in_ready   operands can be accepted (high only while idle)
//    a, b, bin  minuend, subtrahend, borrow-in; sampled on accept
//    out_valid  result valid (high only while the result is presented)
//    out_ready  consumer accepts the result
//    diff       registered difference, modulo 2^WIDTH
//    bout       final borrow-out, 1 iff unsigned a < b + bin
//    zero       diff == 0
//    neg        diff[WIDTH-1]
//    ovf        signed overflow of a - b - bin
module block_serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             zero,
   output logic             neg,
   output logic             ovf
);

   localparam int SLICES = WIDTH / BLOCK;
   localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] diff_next;
   logic [IW-1:0]    idx;
   logic             borrow;
   logic [BLOCK-1:0] a_slice;
   logic [BLOCK-1:0] b_slice;
   logic [BLOCK:0]   ripple;
   logic             slice_bout;
   logic             last_slice;

   // Handshake outputs are pure decodes of the state register.
   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign last_slice = (idx == IW'(SLICES - 1));

   // One slice of the subtraction. The extra top bit of the ripple result is
   // the slice's own borrow-out. When the two slices are equal the difference
   // is just -borrow, so the incoming borrow passes straight through instead
   // of waiting on the ripple chain. diff_next is the full result as it will
   // look after this slice is written, so the flags can be derived from it on
   // the last slice without an extra cycle.
   always_comb begin
      a_slice    = a_reg[idx*BLOCK +: BLOCK];
      b_slice    = b_reg[idx*BLOCK +: BLOCK];
      ripple     = {1'b0, a_slice} - {1'b0, b_slice} - {{BLOCK{1'b0}}, borrow};
      slice_bout = (a_slice == b_slice) ? borrow : ripple[BLOCK];
      diff_next  = diff;
      diff_next[idx*BLOCK +: BLOCK] = ripple[BLOCK-1:0];
   end

   // State register; reset always returns to idle, even mid-calculation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode. DONE exits on the consumer handshake, and the exit
   // cycle itself never accepts operands because in_ready is low in DONE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid) state_next = CALC;
         CALC: if (last_slice) state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers. Operands are captured on accept so later input
   // changes have no effect. Each CALC cycle writes one slice of diff and
   // advances the borrow; the final slice also loads bout and the flags,
   // which then hold through DONE and idle until the next result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg  <= '0;
         b_reg  <= '0;
         idx    <= '0;
         borrow <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
         zero   <= 1'b0;
         neg    <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg  <= a;
                  b_reg  <= b;
                  borrow <= bin;
                  idx    <= '0;
               end
            end
            CALC: begin
               diff   <= diff_next;
               borrow <= slice_bout;
               idx    <= idx + IW'(1);
               if (last_slice) begin
                  bout <= slice_bout;
                  zero <= (diff_next == '0);
                  neg  <= diff_next[WIDTH-1];
                  ovf  <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                          (diff_next[WIDTH-1] != a_reg[WIDTH-1]);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
